div_seq_unit: RTL
=================

// Module: div_seq_unit
// PURPOSE
//   Multi-cycle RV32M divide/remainder responder (DIV, DIVU, REM, REMU). The ALU issue logic
//   hands it operands and funct3 over a valid/ready request channel; the quotient or remainder
//   returns over a valid/ready response channel. Radix-2 restoring, one quotient bit per cycle.
//   Replaces single-cycle combinational division on the execute path.
// PARAMETERS
//   XLEN      32   operand/result width; iteration count equals XLEN
// PORTS
//   clk         in   1     rising-edge clock, sole clock
//   reset       in   1     asynchronous, active-high reset
//   req_valid   in   1     request present
//   req_ready   out  1     unit can accept a request
//   req_funct3  in   3     3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU
//   req_a       in   XLEN  dividend (BusWires1)
//   req_b       in   XLEN  divisor (BusWires2)
//   kill        in   1     abort in-flight op (pipeline flush)
//   resp_valid  out  1     result available
//   resp_ready  in   1     consumer takes result
//   resp_data   out  XLEN  quotient or remainder per funct3
//   busy        out  1     state != IDLE
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, busy=0,
//     internal registers=0.
//   - FSM IDLE -> CALC -> DONE -> IDLE.
//     IDLE: req_ready=1. req_valid&&req_ready at edge E0 latches funct3, |a|, |b|, sign flags
//       (signed ops only; unsigned ops take operands as-is), clears remainder, count=0 -> CALC.
//       req_funct3[2]==0 is a protocol error: request accepted, result 0, still 32 cycles.
//     CALC: req_ready=0. Each edge: rem={rem[XLEN-2:0],dvd[XLEN-1]}; trial=rem-|b|;
//       if trial>=0 then rem=trial, quotient bit=1 else bit=0; count++. After XLEN edges (E32)
//       apply sign correction and load resp_data -> DONE.
//     DONE: resp_valid=1, resp_data held stable. resp_ready at edge -> IDLE, resp_valid=0.
//       No new request accepted in the same cycle as response handshake (req_ready=0 in DONE).
//   - Latency: resp_valid rises at edge E0+XLEN; throughput 1 op per XLEN+2 cycles minimum.
//   - Sign rules (signed ops): quotient negative iff sign(a)^sign(b); remainder takes sign(a).
//   - Corner cases (RISC-V spec, mandatory):
//     b==0: DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> a.
//     DIV a=32'h80000000,b=32'hFFFFFFFF: quotient 32'h80000000, REM result 0.
//   - kill: any state -> IDLE next edge, resp_valid=0, result discarded; kill with req_valid in
//     IDLE blocks acceptance that cycle. kill has priority over resp_ready.
//   - resp_valid never deasserts without handshake or kill; resp_data stable while valid.
// CONFIGURATION
//   DIV_EARLY_OUT_EN defined: at acceptance, b==0 or signed overflow detected; unit skips CALC
//     and enters DONE at E0 with spec result (resp_valid high 1 cycle after accept).
//     Also: |a|<|b| skips to DONE with quotient 0, remainder a.
//   Not defined: every op takes full XLEN CALC cycles; corner results produced at E32.
// TESTING
//   1 DIVU a=100,b=7 -> resp_data=14 at edge E0+32; REMU same operands -> 2.
//   2 DIV a=-7 (32'hFFFFFFF9),b=2 -> 32'hFFFFFFFD (-3); REM -> 32'hFFFFFFFF (-1).
//   3 DIVU a=5,b=0 -> 32'hFFFFFFFF; REM a=5,b=0 -> 5; with DIV_EARLY_OUT_EN resp 1 cycle after.
//   4 DIV a=32'h80000000,b=-1 -> 32'h80000000; REM -> 0.
//   5 Hold resp_ready=0 for 10 cycles in DONE -> resp_valid/resp_data stable, req_ready=0;
//     release -> IDLE next edge, next request accepted.
//   6 Assert reset at count=15, then kill at count=15 on a separate op -> IDLE,
//     resp_valid=0, no stale response; following DIVU 9/3 returns 3.

Source files
------------

// File: rtl/div_seq_unit.sv
// Sequential RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |a|<|b| finish at acceptance.
module div_seq_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [XLEN-1:0]   div_q, div_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   resp_q, resp_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              bzero_q, bzero_d;
    logic              err_q, err_d;

    logic              signed_op, a_neg, b_neg, accept, ge;
    logic [XLEN-1:0]   abs_a, abs_b, rem_step, quo_step, q_fin, r_fin, result;
    logic [XLEN:0]     shifted;

    assign signed_op = ~req_funct3[0];
    assign a_neg     = signed_op & req_a[XLEN-1];
    assign b_neg     = signed_op & req_b[XLEN-1];
    assign abs_a     = a_neg ? -req_a : req_a;
    assign abs_b     = b_neg ? -req_b : req_b;
    assign accept    = req_valid & req_ready & ~kill;

    // Partial remainder needs one extra bit: it can reach 2*divisor-1 before the subtract.
    assign shifted   = {rem_q, dvd_q[XLEN-1]};
    assign ge        = shifted >= {1'b0, div_q};
    assign rem_step  = ge ? (shifted[XLEN-1:0] - div_q) : shifted[XLEN-1:0];
    assign quo_step  = {dvd_q[XLEN-2:0], ge};
    assign q_fin     = qneg_q ? -quo_step : quo_step;
    assign r_fin     = rneg_q ? -rem_step : rem_step;

    always_comb begin
        result = q_fin;
        if (err_q) begin
            result = '0;
        end else if (funct3_q[1]) begin
            result = r_fin;
        end else if (bzero_q) begin
            result = '1;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    logic            early_hit;
    logic [XLEN-1:0] early_res;
    always_comb begin
        early_hit = 1'b0;
        early_res = '0;
        if (req_funct3[2]) begin
            if (req_b == '0) begin
                early_hit = 1'b1;
                early_res = req_funct3[1] ? req_a : '1;
            end else if (signed_op && req_a == {1'b1, {(XLEN-1){1'b0}}} && req_b == '1) begin
                early_hit = 1'b1;
                early_res = req_funct3[1] ? '0 : req_a;
            end else if (abs_a < abs_b) begin
                early_hit = 1'b1;
                early_res = req_funct3[1] ? req_a : '0;
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        dvd_d    = dvd_q;
        div_d    = div_q;
        rem_d    = rem_q;
        resp_d   = resp_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        bzero_d  = bzero_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    funct3_d = req_funct3;
                    dvd_d    = abs_a;
                    div_d    = abs_b;
                    rem_d    = '0;
                    cnt_d    = '0;
                    qneg_d   = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    bzero_d  = (req_b == '0);
                    err_d    = ~req_funct3[2];
                    state_d  = StCalc;
`ifdef DIV_EARLY_OUT_EN
                    if (early_hit) begin
                        resp_d  = early_res;
                        state_d = StDone;
                    end
`endif
                end
            end
            StCalc: begin
                rem_d = rem_step;
                dvd_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(XLEN - 1)) begin
                    resp_d  = result;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (kill) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            funct3_q <= '0;
            dvd_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            resp_q   <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            dvd_q    <= dvd_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            resp_q   <= resp_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            bzero_q  <= bzero_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign resp_data  = resp_q;

endmodule
